// File: rtl/e1_wb_rx.sv
// E1 receive-path Wishbone control: CSRs, empty/filled BD FIFOs, CRC4 E-bit tracking and RX IRQ.
// Optional define E1_WB_RX_FLUSH_EN: ctrl write bit 13 empties both BD FIFOs.
module e1_wb_rx #(
  parameter int unsigned MFW = 7
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           bus_addr_sel,
  input  logic           bus_addr_lsb,
  input  logic [15:0]    bus_wdata,
  output logic [15:0]    bus_rdata,
  input  logic           bus_clr,
  input  logic           bus_we,
  output logic [MFW-1:0] bd_mf,
  output logic           bd_valid,
  input  logic           bd_done,
  input  logic [1:0]     bd_crc_e,
  input  logic           bd_miss,
  input  logic           core_aligned,
  output logic [1:0]     ctrl_mode,
  output logic           ctrl_rst,
  output logic [1:0]     rx_crc_e_auto,
  input  logic           rx_crc_e_ack,
  output logic           irq
);

  localparam int unsigned DEPTH = 4;
  localparam int unsigned PW    = 2;
  localparam int unsigned CW    = 3;
  localparam int unsigned BOW   = MFW + 2;

  logic           ctrl_wren_q, ctrl_wren_d;
  logic           bri_wren_q, bri_wren_d;
  logic           bro_rden_q, bro_rden_d;
  logic [15:0]    wdata_q, wdata_d;
  logic           enable_q, enable_d;
  logic [1:0]     mode_q, mode_d;
  logic           ctrl_rst_q, ctrl_rst_d;
  logic           ovf_q, ovf_d;
  logic [1:0]     crc_acc_q, crc_acc_d;

  logic [MFW-1:0] bri_mem_q [DEPTH];
  logic [MFW-1:0] bri_mem_d [DEPTH];
  logic [PW-1:0]  bri_rd_q, bri_rd_d, bri_wr_q, bri_wr_d;
  logic [CW-1:0]  bri_cnt_q, bri_cnt_d;
  logic [BOW-1:0] bro_mem_q [DEPTH];
  logic [BOW-1:0] bro_mem_d [DEPTH];
  logic [PW-1:0]  bro_rd_q, bro_rd_d, bro_wr_q, bro_wr_d;
  logic [CW-1:0]  bro_cnt_q, bro_cnt_d;

  logic           bri_empty, bri_full, bro_empty, bro_full;
  logic           bri_push, bri_pop, bro_push, bro_pop, bro_drop;
  logic [BOW-1:0] bro_head;
  logic [15:0]    bd_word, status_word;
  logic           unused_wdata_c;

`ifdef E1_WB_RX_FLUSH_EN
  logic           flush_q, flush_d;
`endif

  assign bri_empty = (bri_cnt_q == CW'(0));
  assign bri_full  = (bri_cnt_q == CW'(DEPTH));
  assign bro_empty = (bro_cnt_q == CW'(0));
  assign bro_full  = (bro_cnt_q == CW'(DEPTH));
  assign bro_head  = bro_mem_q[bro_rd_q];
  assign unused_wdata_c = ^wdata_q;

  // Bus strobes, qualified at access time and applied one cycle later
  always_comb begin
    ctrl_wren_d = ~bus_clr & bus_we & bus_addr_sel & ~bus_addr_lsb;
    bri_wren_d  = ~bus_clr & bus_we & bus_addr_sel & bus_addr_lsb & ~bri_full;
    bro_rden_d  = ~bus_clr & ~bus_we & bus_addr_sel & bus_addr_lsb & ~bro_empty;
    wdata_d     = bus_wdata;
  end

  // FIFO handshakes; a full bro discards the filled BD
  always_comb begin
    bri_pop  = bd_done & ~bri_empty;
    bri_push = bri_wren_q & (~bri_full | bri_pop);
    bro_push = bri_pop & ~bro_full;
    bro_drop = bri_pop & bro_full;
    bro_pop  = bro_rden_q & ~bro_empty;
  end

  always_comb begin
    bri_mem_d = bri_mem_q;
    bri_rd_d  = bri_rd_q;
    bri_wr_d  = bri_wr_q;
    bri_cnt_d = bri_cnt_q + CW'(bri_push) - CW'(bri_pop);
    bro_mem_d = bro_mem_q;
    bro_rd_d  = bro_rd_q;
    bro_wr_d  = bro_wr_q;
    bro_cnt_d = bro_cnt_q + CW'(bro_push) - CW'(bro_pop);
    if (bri_push) begin
      bri_mem_d[bri_wr_q] = wdata_q[MFW-1:0];
      bri_wr_d            = bri_wr_q + PW'(1);
    end
    if (bri_pop) bri_rd_d = bri_rd_q + PW'(1);
    if (bro_push) begin
      bro_mem_d[bro_wr_q] = {bd_crc_e, bri_mem_q[bri_rd_q]};
      bro_wr_d            = bro_wr_q + PW'(1);
    end
    if (bro_pop) bro_rd_d = bro_rd_q + PW'(1);
`ifdef E1_WB_RX_FLUSH_EN
    // Flush overrides any same-cycle push or pop
    if (flush_q) begin
      bri_rd_d  = '0;
      bri_wr_d  = '0;
      bri_cnt_d = '0;
      bro_rd_d  = '0;
      bro_wr_d  = '0;
      bro_cnt_d = '0;
    end
`endif
  end

  // Control/status registers; overflow set wins over clear
  always_comb begin
    enable_d   = enable_q;
    mode_d     = mode_q;
    ovf_d      = ovf_q;
    ctrl_rst_d = ~enable_q;
    if (ctrl_wren_q) begin
      enable_d = wdata_q[0];
      mode_d   = wdata_q[2:1];
      if (wdata_q[12]) ovf_d = 1'b0;
    end
    if (bd_miss | bro_drop) ovf_d = 1'b1;
    crc_acc_d = (rx_crc_e_ack ? 2'b00 : crc_acc_q) | (bd_done ? bd_crc_e : 2'b00);
  end

`ifdef E1_WB_RX_FLUSH_EN
  assign flush_d = ctrl_wren_q & wdata_q[13];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) flush_q <= 1'b0;
    else     flush_q <= flush_d;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_wren_q <= 1'b0;
      bri_wren_q  <= 1'b0;
      bro_rden_q  <= 1'b0;
      wdata_q     <= '0;
      enable_q    <= 1'b0;
      mode_q      <= 2'b00;
      ctrl_rst_q  <= 1'b1;
      ovf_q       <= 1'b0;
      crc_acc_q   <= 2'b00;
      bri_rd_q    <= '0;
      bri_wr_q    <= '0;
      bri_cnt_q   <= '0;
      bro_rd_q    <= '0;
      bro_wr_q    <= '0;
      bro_cnt_q   <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        bri_mem_q[i] <= '0;
        bro_mem_q[i] <= '0;
      end
    end else begin
      ctrl_wren_q <= ctrl_wren_d;
      bri_wren_q  <= bri_wren_d;
      bro_rden_q  <= bro_rden_d;
      wdata_q     <= wdata_d;
      enable_q    <= enable_d;
      mode_q      <= mode_d;
      ctrl_rst_q  <= ctrl_rst_d;
      ovf_q       <= ovf_d;
      crc_acc_q   <= crc_acc_d;
      bri_rd_q    <= bri_rd_d;
      bri_wr_q    <= bri_wr_d;
      bri_cnt_q   <= bri_cnt_d;
      bro_rd_q    <= bro_rd_d;
      bro_wr_q    <= bro_wr_d;
      bro_cnt_q   <= bro_cnt_d;
      bri_mem_q   <= bri_mem_d;
      bro_mem_q   <= bro_mem_d;
    end
  end

  // Read mux: status word or the bro head descriptor
  always_comb begin
    status_word = {3'b000, ovf_q, bro_full, bro_empty, bri_full, bri_empty,
                   6'b000000, core_aligned, enable_q};
    bd_word              = '0;
    bd_word[15]          = ~bro_empty;
    bd_word[14:13]       = bro_head[BOW-1:MFW];
    bd_word[MFW-1:0]     = bro_head[MFW-1:0];
    bus_rdata            = '0;
    if (bus_addr_sel) bus_rdata = bus_addr_lsb ? bd_word : status_word;
  end

  assign bd_valid      = ~bri_empty;
  assign bd_mf         = bri_mem_q[bri_rd_q];
  assign ctrl_mode     = mode_q;
  assign ctrl_rst      = ctrl_rst_q;
  assign rx_crc_e_auto = crc_acc_q;
  assign irq           = ~bro_empty | ovf_q;

endmodule
